// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage with a registered carry
// between stages; the last stage register drives the result and flags.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] Sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the rising edge. The whole pipe freezes only when a finished result
  // is waiting (stall), so in_ready is simply the inverse of stall.
  logic stall;

  // Operands are kept MSB-left internally; A[0] lands in a_in[WIDTH-1].
  logic [WIDTH-1:0] a_in, b_in;
  assign a_in = A;
  assign b_in = sub ? ~B : B;

  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic             ovf_q, zero_q;

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];

  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic [CHUNK:0]   part;
  logic             ovf_d, zero_d, carry_into_msb;

  always_comb begin
    src_a[0] = a_in;
    src_b[0] = b_in;
    src_s[0] = '0;
    src_c[0] = sub | cin;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = st_a[k-1];
      src_b[k] = st_b[k-1];
      src_s[k] = st_s[k-1];
      src_c[k] = st_c[k-1];
      src_v[k] = st_v[k-1];
    end
  end

  // Stage k fills slice k of the running sum; bit CHUNK of the slice add is the carry.
  always_comb begin
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(src_c[k]);
      nx_s[k] = src_s[k];
      nx_s[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      nx_c[k] = part[CHUNK];
    end
  end

  // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out of it.
  always_comb begin
    carry_into_msb = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ nx_s[LAST][WIDTH-1];
    ovf_d          = carry_into_msb ^ nx_c[LAST];
    zero_d         = (nx_s[LAST] == '0);
  end

  assign stall    = st_v[LAST] & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= 1'b0;
        st_c[k] <= 1'b0;
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= src_v[k];
        st_c[k] <= nx_c[k];
        st_a[k] <= src_a[k];
        st_b[k] <= src_b[k];
        st_s[k] <= nx_s[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = st_v[LAST];
  assign Sum       = st_s[LAST];
  assign cout      = st_c[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: reset, flag vectors, streaming,
// backpressure, mid-operation reset and a small parameter sweep.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic        cout, overflow, zero;
  logic [31:0] a, b, sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  logic        s_cin, s_sub;
  logic        iv8, ir8, ov8, co8, of8, z8;
  logic        iv16, ir16, ov16, co16, of16, z16;
  logic        iv64, ir64, ov64, co64, of64, z64;
  logic [7:0]  a8, b8, sum8;
  logic [15:0] a16, b16, sum16;
  logic [63:0] a64, b64, sum64;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .cin(s_cin), .sub(s_sub), .out_valid(ov8), .out_ready(1'b1), .Sum(sum8),
    .cout(co8), .overflow(of8), .zero(z8)
  );
  pipelined_adder #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .cin(s_cin), .sub(s_sub), .out_valid(ov16), .out_ready(1'b1), .Sum(sum16),
    .cout(co16), .overflow(of16), .zero(z16)
  );
  pipelined_adder #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
    .cin(s_cin), .sub(s_sub), .out_valid(ov64), .out_ready(1'b1), .Sum(sum64),
    .cout(co64), .overflow(of64), .zero(z64)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];  // {cout, overflow, zero, sum}

  function automatic logic [34:0] exp_add(logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] f;
    logic        v;
    f = {1'b0, x} + {1'b0, y} + {32'b0, c};
    v = (x[31] == y[31]) && (f[31] != x[31]);
    return {f[32], v, f[31:0] == 32'h0, f[31:0]};
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv8 = 1'b0; iv16 = 1'b0; iv64 = 1'b0; s_cin = 1'b0; s_sub = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0; a64 = '0; b64 = '0;
  endtask

  task automatic test_reset();
    int seen;
    drive_idle();
    reset = 1'b1;
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 32'h0) begin n_bad++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
    n_cmp++; if ({cout, overflow, zero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {cout, overflow, zero}); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_no_output got=%0d exp=0", seen); end
  endtask

  task automatic test_directed();
    logic [100:0] vec [7];
    logic [100:0] v;
    int n;
    vec[0] = {32'h0000F000, 32'h0000F000, 1'b0, 1'b0, 32'h0001E000, 3'b000};
    vec[1] = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 3'b101};
    vec[2] = {32'hFFFFFFFD, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b000};
    vec[3] = {32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 3'b010};
    vec[4] = {32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 3'b000};
    vec[5] = {32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 3'b101};
    vec[6] = {32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 3'b110};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v = vec[i];
      @(posedge clk); #1;
      in_valid = 1'b1; a = v[100:69]; b = v[68:37]; cin = v[36]; sub = v[35];
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL dir%0d_latency got=%0d exp=4", i, n); end
      n_cmp++; if (sum !== v[34:3]) begin n_bad++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, v[34:3]); end
      n_cmp++; if (cout !== v[2]) begin n_bad++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, v[2]); end
      n_cmp++; if (overflow !== v[1]) begin n_bad++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, overflow, v[1]); end
      n_cmp++; if (zero !== v[0]) begin n_bad++; $display("FAIL dir%0d_zero got=%b exp=%b", i, zero, v[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int idx, got, first, last;
    logic [34:0] e;
    exp_q.delete();
    idx = 0; got = 0; first = -1; last = -1; out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk); #1;
      if (idx < 8) begin
        in_valid = 1'b1; a = 32'h1111_1111 * (idx + 1); b = 32'h8000_0000 >> idx;
        cin = idx[0]; sub = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_extra got=%h exp=none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({cout, overflow, zero, sum} !== e) begin
            n_bad++; $display("FAIL b2b_result got=%h exp=%h", {cout, overflow, zero, sum}, e);
          end
        end
        if (first < 0) first = c;
        last = c; got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(exp_add(a, b, cin)); idx++; end
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
    n_cmp++; if (last - first !== 7) begin n_bad++; $display("FAIL b2b_consecutive got=%0d exp=7", last - first); end
  endtask

  task automatic test_backpressure();
    int idx, got;
    logic [34:0] e, held;
    exp_q.delete();
    idx = 0; got = 0; held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 6 && c < 9);
      if (idx < 8) begin
        in_valid = 1'b1; a = 32'hF0F0_F0F0 + idx; b = 32'h0F0F_0F10 * (idx + 1);
        cin = ~idx[0]; sub = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
        if (c == 6) held = {cout, overflow, zero, sum};
        else begin
          n_cmp++;
          if ({cout, overflow, zero, sum} !== held) begin
            n_bad++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, {cout, overflow, zero, sum}, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra got=%h exp=none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({cout, overflow, zero, sum} !== e) begin
            n_bad++; $display("FAIL bp_result got=%h exp=%h", {cout, overflow, zero, sum}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(exp_add(a, b, cin)); idx++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp_count got=%0d exp=8", got); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'h0101_0101 * (i + 1); b = 32'h2000_0000; cin = 1'b0; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 32'h0) begin n_bad++; $display("FAIL midrst_sum got=%h exp=00000000", sum); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_stale got=%0d exp=0", seen); end
  endtask

  task automatic ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                         input logic c, input logic s, output logic [63:0] rs,
                         output logic rco, output logic rov, output logic rz);
    logic [64:0] m65, full, low;
    logic [63:0] mask, half, bx;
    logic        c0;
    m65  = (65'd1 << w) - 65'd1;
    mask = m65[63:0];
    half = mask >> 1;
    bx   = (s ? ~y : y) & mask;
    c0   = s | c;
    full = {1'b0, x & mask} + {1'b0, bx} + {64'b0, c0};
    low  = {1'b0, x & half} + {1'b0, bx & half} + {64'b0, c0};
    rs   = full[63:0] & mask;
    rco  = full[w];
    rov  = low[w-1] ^ rco;
    rz   = (rs == 64'h0);
  endtask

  task automatic test_param_sweep();
    int widths [3];
    int stages [3];
    logic [63:0] ra, rb, es, gs;
    logic eco, eov, ez, gco, gov, gz, gv, gr;
    int n;
    widths[0] = 8;  widths[1] = 16; widths[2] = 64;
    stages[0] = 1;  stages[1] = 2;  stages[2] = 8;
    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 6; t++) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        if (t == 0) begin ra = '1; rb = 64'h1; end
        @(posedge clk); #1;
        s_cin = 1'($urandom_range(0, 1)); s_sub = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        case (d)
          0: begin a8 = ra[7:0];   b8 = rb[7:0];   iv8 = 1'b1;  gr = ir8;  end
          1: begin a16 = ra[15:0]; b16 = rb[15:0]; iv16 = 1'b1; gr = ir16; end
          default: begin a64 = ra; b64 = rb;       iv64 = 1'b1; gr = ir64; end
        endcase
        ref_add(widths[d], ra, rb, s_cin, s_sub, es, eco, eov, ez);
        n_cmp++; if (gr !== 1'b1) begin n_bad++; $display("FAIL sweep_w%0d_in_ready got=%b exp=1", widths[d], gr); end
        @(posedge clk); #1;
        iv8 = 1'b0; iv16 = 1'b0; iv64 = 1'b0;
        n = 1;
        gv = (d == 0) ? ov8 : (d == 1) ? ov16 : ov64;
        while (!gv && n < 30) begin
          @(posedge clk); #1; n++;
          gv = (d == 0) ? ov8 : (d == 1) ? ov16 : ov64;
        end
        case (d)
          0: begin gs = {56'h0, sum8};  gco = co8;  gov = of8;  gz = z8;  end
          1: begin gs = {48'h0, sum16}; gco = co16; gov = of16; gz = z16; end
          default: begin gs = sum64;    gco = co64; gov = of64; gz = z64; end
        endcase
        n_cmp++; if (n !== stages[d]) begin n_bad++; $display("FAIL sweep_w%0d_latency got=%0d exp=%0d", widths[d], n, stages[d]); end
        n_cmp++;
        if ({gco, gov, gz, gs} !== {eco, eov, ez, es}) begin
          n_bad++; $display("FAIL sweep_w%0d_result got=%b%b%b_%h exp=%b%b%b_%h",
                            widths[d], gco, gov, gz, gs, eco, eov, ez, es);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
